cxapbasyncbridge_slv_seq: RTL and testbench
===========================================

Name: cxapbasyncbridge_slv_seq

Overview:
- Slave-domain sequencer of the APB asynchronous bridge.
- Receives a 4-phase req/ack handshake from the master domain and drives the valid (payload_en) input of the combinational CDC clamps on the request payload.
- Registers the clamped payload, runs one APB transfer on the slave-side bus, and holds the response stable for the master domain while ack is high.

Parameters:
ADDR_WIDTH  12  width of PADDRS / paddr_q
DATA_WIDTH  32  width of PWDATAS, PRDATAS, pwdata_q, prdata_s
SYNC_STAGES  2  synchroniser depth on req_async; legal values >= 2

Ports:
PCLKS  in  1  slave-domain clock
PRESETnS  in  1  asynchronous active-low reset
req_async  in  1  handshake request level from master domain, unsynchronised
ack_s  out  1  handshake acknowledge level, registered, to master domain
payload_en  out  1  registered valid to request-payload CDC clamps
paddr_q  in  ADDR_WIDTH  clamped address (zero when payload_en=0)
pwrite_q  in  1  clamped direction
pwdata_q  in  DATA_WIDTH  clamped write data
PSELS  out  1  APB select
PENABLES  out  1  APB enable
PADDRS  out  ADDR_WIDTH  APB address
PWRITES  out  1  APB direction
PWDATAS  out  DATA_WIDTH  APB write data
PRDATAS  in  DATA_WIDTH  APB read data
PREADYS  in  1  APB ready
PSLVERRS  in  1  APB error
prdata_s  out  DATA_WIDTH  registered response data; stable while ack_s=1
pslverr_s  out  1  registered response error; stable while ack_s=1

Behaviour:
- PCLKS is the only clock. PRESETnS is asynchronous assert, active low; all flops are clocked by PCLKS.
- req_async passes through a SYNC_STAGES flop chain to give req_sync. No other input is synchronised.
- FSM states: IDLE, CAPTURE, SETUP, ACCESS, ACK.
- IDLE: if req_sync=1, go to CAPTURE and set payload_en=1.
- CAPTURE: payload_en=1 for exactly one cycle. At the end of the cycle, register paddr_q->PADDRS, pwrite_q->PWRITES, pwdata_q->PWDATAS. Go to SETUP and clear payload_en.
- SETUP: PSELS=1, PENABLES=0. Go to ACCESS.
- ACCESS: PSELS=1, PENABLES=1. Stay while PREADYS=0. When PREADYS=1:
  - register prdata_s = PRDATAS if PWRITES=0, else 0;
  - register pslverr_s = PSLVERRS;
  - clear PSELS and PENABLES, set ack_s=1, go to ACK.
- ACK: ack_s=1. When req_sync=0, clear ack_s and go to IDLE.
- prdata_s and pslverr_s hold until the next ACCESS completion. They are not cleared on ack fall.
- PADDRS, PWRITES, PWDATAS hold their last value outside a transfer.
- Latency, SYNC_STAGES=2, zero APB wait states, req_async first sampled high at edge n:
  - req_sync=1 after edge n+1;
  - CAPTURE/payload_en=1 after n+2;
  - SETUP after n+3;
  - ACCESS after n+4;
  - ack_s=1 after n+5.
  - Each PREADYS=0 cycle adds one cycle. Each extra sync stage adds one cycle.
- Release: req_async first sampled low at edge m -> ack_s=0 after edge m+2. A new request can enter CAPTURE no earlier than the cycle after IDLE is re-entered.
- Protocol violation: req_sync falling outside ACK is ignored. The transfer completes, and ACK then exits on its first cycle. No spurious second transfer is issued.
- Reset (any state, including mid-ACCESS):
  - all outputs go to 0, FSM goes to IDLE, the sync chain clears;
  - the interrupted APB transfer is abandoned;
  - after reset release, a still-high req_async starts a fresh transfer with normal latency.
- payload_en is a flop output, never combinational from req_async. It is high only in CAPTURE.

Test Plan:
- Write, PREADYS=1: req rises with paddr=0x0A4, pwdata=0xDEADBEEF, pwrite=1 -> payload_en high for 1 cycle at n+2. APB SETUP at n+3 with PADDRS=0x0A4, PWDATAS=0xDEADBEEF. ack_s=1 at n+5. prdata_s=0. ack_s=0 two cycles after req falls.
- Read, 3 wait states: PRDATAS=0x12345678 with PREADYS low 3 cycles -> ACCESS lasts 4 cycles, ack_s=1 at n+8, prdata_s=0x12345678, pslverr_s=0, held through ACK.
- Error response: PSLVERRS=1 with PREADYS -> pslverr_s=1, ack_s=1. Next OK transfer clears pslverr_s to 0.
- Clamp check: payload_q forced to 0 whenever payload_en=0 -> PADDRS/PWDATAS never latch values outside CAPTURE. payload_en=1 only in CAPTURE.
- Reset mid-ACCESS: PRESETnS low while PSELS=PENABLES=1 -> all outputs 0 immediately. Release with req_async high -> new transfer, ack_s=1 at release+5.
- Back-to-back: req falls and rises again as soon as ack_s falls -> second transfer executes exactly once, with no lost or duplicated PSELS pulse.

Source files
------------

// File: rtl/cxapbasyncbridge_slv_seq_if.sv
// Slave-domain bundle of the APB async bridge: master-domain handshake,
// clamped request payload, slave APB bus and the registered response.
interface cxapbasyncbridge_slv_seq_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req_async;
  logic                  ack_s;
  logic                  payload_en;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  PSELS;
  logic                  PENABLES;
  logic [ADDR_WIDTH-1:0] PADDRS;
  logic                  PWRITES;
  logic [DATA_WIDTH-1:0] PWDATAS;
  logic [DATA_WIDTH-1:0] PRDATAS;
  logic                  PREADYS;
  logic                  PSLVERRS;
  logic [DATA_WIDTH-1:0] prdata_s;
  logic                  pslverr_s;

  modport slave (
    input  req_async, paddr_q, pwrite_q, pwdata_q, PRDATAS, PREADYS, PSLVERRS,
    output ack_s, payload_en, PSELS, PENABLES, PADDRS, PWRITES, PWDATAS,
           prdata_s, pslverr_s
  );

  modport master (
    output req_async, paddr_q, pwrite_q, pwdata_q, PRDATAS, PREADYS, PSLVERRS,
    input  ack_s, payload_en, PSELS, PENABLES, PADDRS, PWRITES, PWDATAS,
           prdata_s, pslverr_s
  );
endinterface

// File: rtl/cxapbasyncbridge_slv_seq.sv
// Slave-domain sequencer: synchronises req, opens the payload clamps for one
// cycle, runs one APB transfer and holds the response while ack is high.
module cxapbasyncbridge_slv_seq #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          PCLKS,
  input  logic                          PRESETnS,
  cxapbasyncbridge_slv_seq_if.slave     bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_ACCESS  = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_sync;
  logic [2:0]             r_state;
  logic                   r_payload_en;
  logic                   r_ack;
  logic                   r_psel;
  logic                   r_penable;
  logic [ADDR_WIDTH-1:0]  r_paddr;
  logic                   r_pwrite;
  logic [DATA_WIDTH-1:0]  r_pwdata;
  logic [DATA_WIDTH-1:0]  r_prdata;
  logic                   r_pslverr;

  always_ff @(posedge PCLKS or negedge PRESETnS) begin
    if (!PRESETnS) r_sync <= '0;
    else           r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_async};
  end

  assign w_req_sync = r_sync[SYNC_STAGES-1];

  // req dropping early is not looked at until ACK, so a violating master
  // still gets exactly one completed transfer.
  always_ff @(posedge PCLKS or negedge PRESETnS) begin
    if (!PRESETnS) begin
      r_state      <= S_IDLE;
      r_payload_en <= 1'b0;
      r_ack        <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_prdata     <= '0;
      r_pslverr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req_sync) begin
          r_state      <= S_CAPTURE;
          r_payload_en <= 1'b1;
        end
        S_CAPTURE: begin
          r_paddr      <= bus.paddr_q;
          r_pwrite     <= bus.pwrite_q;
          r_pwdata     <= bus.pwdata_q;
          r_payload_en <= 1'b0;
          r_psel       <= 1'b1;
          r_state      <= S_SETUP;
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: if (bus.PREADYS) begin
          r_prdata  <= r_pwrite ? '0 : bus.PRDATAS;
          r_pslverr <= bus.PSLVERRS;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_ack     <= 1'b1;
          r_state   <= S_ACK;
        end
        S_ACK: if (!w_req_sync) begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_payload_en <= 1'b0;
          r_ack        <= 1'b0;
          r_psel       <= 1'b0;
          r_penable    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.payload_en = r_payload_en;
  assign bus.ack_s      = r_ack;
  assign bus.PSELS      = r_psel;
  assign bus.PENABLES   = r_penable;
  assign bus.PADDRS     = r_paddr;
  assign bus.PWRITES    = r_pwrite;
  assign bus.PWDATAS    = r_pwdata;
  assign bus.prdata_s   = r_prdata;
  assign bus.pslverr_s  = r_pslverr;
endmodule

// File: tb/tb_cxapbasyncbridge_slv_seq.sv
// Bench for the slave-domain sequencer: master-side clamp model, APB slave
// model with programmable wait states and a per-transfer expectation model.
module tb_cxapbasyncbridge_slv_seq;
  logic PCLKS = 1'b0;
  logic PRESETnS = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [11:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic        m_wr    = 1'b0;

  // response the sequencer should be presenting
  logic [31:0] mdl_prdata = '0;
  logic        mdl_err    = 1'b0;

  cxapbasyncbridge_slv_seq_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  cxapbasyncbridge_slv_seq #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .PCLKS    (PCLKS),
    .PRESETnS (PRESETnS),
    .bus      (bus)
  );

  always #5 PCLKS = ~PCLKS;

  assign bus.paddr_q  = bus.payload_en ? m_addr  : '0;
  assign bus.pwdata_q = bus.payload_en ? m_wdata : '0;
  assign bus.pwrite_q = bus.payload_en ? m_wr    : 1'b0;

  task automatic start_req(input logic [11:0] a, input logic [31:0] d, input logic w,
                           input logic [31:0] rd, input logic e);
    m_addr = a; m_wdata = d; m_wr = w;
    bus.PRDATAS = rd; bus.PSLVERRS = e; bus.PREADYS = 1'b0;
    bus.req_async = 1'b1;
  endtask

  // Edge 0 is the first edge sampling req high; ack expected after edge 5+waits.
  task automatic run_xfer(input int waits, input int drop_at, input logic [11:0] a,
                          input logic [31:0] d, input logic w, input logic [31:0] rd,
                          input logic e);
    int cnt = -1, pe = 0, sel = 0, acc = 0;
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge PCLKS); #1; cnt++;
      if (drop_at >= 0 && cnt == drop_at) bus.req_async = 1'b0;
      if (bus.payload_en) begin
        pe++; n_cmp++;
        if (cnt != 2) begin n_err++; $display("FAIL payload_en_edge: got %0d want 2", cnt); end
      end
      if (bus.PSELS && !bus.PENABLES) begin
        sel++; n_cmp++;
        if (cnt != 3 || bus.PADDRS !== a || bus.PWDATAS !== d || bus.PWRITES !== w) begin
          n_err++;
          $display("FAIL setup: edge %0d addr %h data %h wr %b want edge 3 addr %h data %h wr %b",
                   cnt, bus.PADDRS, bus.PWDATAS, bus.PWRITES, a, d, w);
        end
      end
      if (cnt >= 3) begin m_addr = 12'($urandom); m_wdata = $urandom; m_wr = 1'($urandom); end
      if (bus.PSELS && bus.PENABLES) begin acc++; bus.PREADYS = (acc > waits); end
      if (bus.ack_s) begin
        done = 1; n_cmp++;
        if (cnt != 5 + waits) begin n_err++; $display("FAIL ack_edge: got %0d want %0d", cnt, 5 + waits); end
      end
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL ack_timeout: got no ack want ack"); end
    mdl_prdata = w ? 32'h0 : rd;
    mdl_err    = e;
    n_cmp++;
    if (pe != 1 || sel != 1) begin
      n_err++; $display("FAIL pulse_count: payload_en %0d setup %0d want 1 1", pe, sel);
    end
    n_cmp++;
    if (bus.prdata_s !== mdl_prdata || bus.pslverr_s !== mdl_err) begin
      n_err++; $display("FAIL response: got %h/%b want %h/%b", bus.prdata_s, bus.pslverr_s, mdl_prdata, mdl_err);
    end
    n_cmp++;
    if (bus.PADDRS !== a || bus.PWDATAS !== d || bus.PSELS !== 1'b0 || bus.PENABLES !== 1'b0) begin
      n_err++; $display("FAIL bus_hold: addr %h data %h sel %b en %b want %h %h 0 0",
                        bus.PADDRS, bus.PWDATAS, bus.PSELS, bus.PENABLES, a, d);
    end
    bus.PREADYS = 1'b0;
  endtask

  // Drop req now; ack must fall after edge 2 while the response stays put.
  task automatic release_req();
    int cnt = -1;
    bit done = 0;
    bus.req_async = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge PCLKS); #1; cnt++;
      bus.PRDATAS = $urandom; bus.PSLVERRS = 1'($urandom);
      n_cmp++;
      if (bus.prdata_s !== mdl_prdata || bus.pslverr_s !== mdl_err) begin
        n_err++; $display("FAIL resp_hold: got %h/%b want %h/%b", bus.prdata_s, bus.pslverr_s, mdl_prdata, mdl_err);
      end
      if (!bus.ack_s) begin
        done = 1; n_cmp++;
        if (cnt != 2) begin n_err++; $display("FAIL ack_release: got edge %0d want 2", cnt); end
      end
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL release_timeout: ack still high"); end
  endtask

  task automatic idle_check(input int cycles);
    logic [11:0] a = bus.PADDRS;
    for (int i = 0; i < cycles; i++) begin
      @(posedge PCLKS); #1;
      m_addr = 12'($urandom);
      n_cmp++;
      if (bus.PSELS || bus.payload_en || bus.ack_s || bus.PADDRS !== a) begin
        n_err++; $display("FAIL idle: sel %b pen %b ack %b addr %h want 0 0 0 %h",
                          bus.PSELS, bus.payload_en, bus.ack_s, bus.PADDRS, a);
      end
    end
  endtask

  task automatic test_reset();
    bus.req_async = 1'b0; bus.PREADYS = 1'b0; bus.PRDATAS = '0; bus.PSLVERRS = 1'b0;
    repeat (3) @(posedge PCLKS);
    #1;
    n_cmp++;
    if ({bus.ack_s, bus.payload_en, bus.PSELS, bus.PENABLES, bus.PADDRS, bus.PWRITES,
         bus.PWDATAS, bus.prdata_s, bus.pslverr_s} !== '0) begin
      n_err++; $display("FAIL reset_state: outputs not all zero");
    end
    PRESETnS = 1'b1;
    idle_check(3);
  endtask

  task automatic test_write();
    logic [31:0] rd = $urandom;
    start_req(12'h0A4, 32'hDEADBEEF, 1'b1, rd, 1'b0);
    run_xfer(0, -1, 12'h0A4, 32'hDEADBEEF, 1'b1, rd, 1'b0);
    release_req();
    idle_check(3);
  endtask

  task automatic test_read_wait();
    start_req(12'h3F0, 32'h0, 1'b0, 32'h12345678, 1'b0);
    run_xfer(3, -1, 12'h3F0, 32'h0, 1'b0, 32'h12345678, 1'b0);
    repeat (3) begin
      @(posedge PCLKS); #1;
      bus.PRDATAS = $urandom;
      n_cmp++;
      if (!bus.ack_s || bus.prdata_s !== 32'h12345678) begin
        n_err++; $display("FAIL ack_hold: ack %b data %h want 1 12345678", bus.ack_s, bus.prdata_s);
      end
    end
    release_req();
    idle_check(2);
  endtask

  task automatic test_error();
    start_req(12'h010, 32'h0, 1'b0, 32'hCAFE0001, 1'b1);
    run_xfer(1, -1, 12'h010, 32'h0, 1'b0, 32'hCAFE0001, 1'b1);
    release_req();
    idle_check(2);
    start_req(12'h020, 32'h55AA55AA, 1'b1, 32'h0, 1'b0);
    run_xfer(0, -1, 12'h020, 32'h55AA55AA, 1'b1, 32'h0, 1'b0);
    release_req();
    idle_check(2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [11:0] a  = 12'($urandom);
      logic [31:0] d  = $urandom;
      logic        w  = 1'($urandom);
      logic [31:0] rd = $urandom;
      logic        e  = 1'($urandom);
      int          ws = int'($urandom_range(0, 4));
      start_req(a, d, w, rd, e);
      run_xfer(ws, -1, a, d, w, rd, e);
      release_req();
      idle_check(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      logic [11:0] a  = 12'($urandom);
      logic [31:0] d  = $urandom;
      logic [31:0] rd = $urandom;
      start_req(a, d, 1'(k), rd, 1'b0);
      run_xfer(k, -1, a, d, 1'(k), rd, 1'b0);
      release_req();
    end
    idle_check(4);
  endtask

  task automatic test_protocol_violation();
    logic [31:0] rd = $urandom;
    start_req(12'h155, 32'h0, 1'b0, rd, 1'b0);
    run_xfer(1, 2, 12'h155, 32'h0, 1'b0, rd, 1'b0);
    @(posedge PCLKS); #1;
    n_cmp++;
    if (bus.ack_s !== 1'b0) begin n_err++; $display("FAIL early_drop_ack: got %b want 0", bus.ack_s); end
    idle_check(8);
  endtask

  task automatic test_reset_mid_access();
    bit hit = 0;
    start_req(12'h777, 32'h0, 1'b0, 32'hABCD0000, 1'b0);
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge PCLKS); #1;
      if (bus.PSELS && bus.PENABLES) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL reach_access: got no ACCESS want ACCESS"); end
    PRESETnS = 1'b0;
    #1;
    mdl_prdata = '0; mdl_err = 1'b0;
    n_cmp++;
    if ({bus.ack_s, bus.payload_en, bus.PSELS, bus.PENABLES, bus.PADDRS, bus.PWRITES,
         bus.PWDATAS, bus.prdata_s, bus.pslverr_s} !== '0) begin
      n_err++; $display("FAIL reset_mid_access: outputs not all zero");
    end
    start_req(12'h0C3, 32'h13579BDF, 1'b1, 32'h0, 1'b0);
    @(posedge PCLKS); @(posedge PCLKS); #1;
    PRESETnS = 1'b1;
    run_xfer(0, -1, 12'h0C3, 32'h13579BDF, 1'b1, 32'h0, 1'b0);
    release_req();
    idle_check(2);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_random();
    test_back_to_back();
    test_protocol_violation();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
